// File: rtl/xup_debounce_vector.sv
// Per-bit switch/button conditioner: 2-flop synchroniser, stability counter and
// registered rise/fall pulses for each of SIZE independent inputs.
module xup_debounce_vector #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned CNT_MAX   = 16,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [SIZE-1:0] a,
  output logic [SIZE-1:0] y,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(CNT_MAX - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  logic [SIZE-1:0]      s1_q, s2_q;
  logic [SIZE-1:0]      y_q, y_d;
  logic [SIZE-1:0]      rise_q, rise_d;
  logic [SIZE-1:0]      fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q [SIZE];
  logic [CNT_WIDTH-1:0] cnt_d [SIZE];

  // A bit counts only while its synchronised input disagrees with its output;
  // agreement clears the counter so a reverted glitch leaves nothing behind.
  always_comb begin
    y_d    = y_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(SIZE); i++) begin
      if (s2_q[i] == y_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntLast) begin
          y_d[i]    = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      y_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      s1_q   <= a;
      s2_q   <= s1_q;
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_xup_debounce_vector.sv
// Directed and randomised checks of xup_debounce_vector (SIZE=4, CNT_MAX=4)
// against a behavioural debounce model.
module tb_xup_debounce_vector;

  localparam int SIZE    = 4;
  localparam int CNT_MAX = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            tick = 1'b1;
  logic [SIZE-1:0] a = '0;
  logic [SIZE-1:0] y, rise, fall;

  xup_debounce_vector #(
    .SIZE     (SIZE),
    .CNT_MAX  (CNT_MAX),
    .CNT_WIDTH(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .a    (a),
    .y    (y),
    .rise (rise),
    .fall (fall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: input seen two edges late; a bit's level flips once its delayed
  // input has disagreed with it for CNT_MAX consecutive tick edges.
  logic [SIZE-1:0] m_s1, m_s2, m_y, m_rise, m_fall;
  int              run [SIZE];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_y = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < SIZE; i++) run[i] = 0;
  endtask

  // One clock cycle: drive inputs while clk is low, raise clk, update the
  // model, compare 1 time unit after the edge, then lower clk.
  task automatic step(input logic t, input logic [SIZE-1:0] av);
    logic [SIZE-1:0] ny, nr, nf;
    tick = t;
    a    = av;
    #4 clk = 1'b1;
    ny = m_y; nr = '0; nf = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (m_s2[i] == m_y[i]) begin
        run[i] = 0;
      end else if (t) begin
        if (run[i] + 1 == CNT_MAX) begin
          ny[i] = m_s2[i];
          nr[i] = m_s2[i];
          nf[i] = ~m_s2[i];
          run[i] = 0;
        end else begin
          run[i]++;
        end
      end
    end
    m_s2 = m_s1; m_s1 = av; m_y = ny; m_rise = nr; m_fall = nf;
    #1;
    check("y", 32'(y), 32'(m_y));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("rise_fall_excl", 32'(rise & fall), 32'h0);
    #4 clk = 1'b0;
    #1;
  endtask

  initial begin
    int edges, t_edges, r3, r0;
    logic [SIZE-1:0] av;

    // Reset with all inputs high.
    a = 4'hF;
    #1 reset = 1'b1;
    #2;
    check("reset_y", 32'(y), 32'h0);
    check("reset_rise", 32'(rise), 32'h0);
    check("reset_fall", 32'(fall), 32'h0);
    model_reset();
    #2 reset = 1'b0;
    #1;

    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 4'hF);
      if (rise == 4'hF) begin edges = k; break; end
    end
    check("release_rise_edge", 32'(edges), 32'd6);
    step(1'b1, 4'hF);
    check("release_rise_once", 32'(rise), 32'h0);
    check("release_y", 32'(y), 32'hF);

    // Clean falling transition.
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 4'h0);
      if (fall == 4'hF) begin edges = k; break; end
    end
    check("fall_edge", 32'(edges), 32'd6);
    step(1'b1, 4'h0);
    check("fall_y", 32'(y), 32'h0);

    // Glitch on a[0]: three cycles high is one short of qualifying.
    for (int k = 0; k < 3; k++) step(1'b1, 4'h1);
    for (int k = 0; k < 8; k++) step(1'b1, 4'h0);
    check("glitch_y", 32'(y), 32'h0);

    // Tick every third cycle; count tick edges after s2[1] is high.
    t_edges = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'((k % 3) == 0), 4'h2);
      if (k >= 3 && (k % 3) == 0) t_edges++;
      if (rise[1]) break;
    end
    check("tick_gate_ticks", 32'(t_edges), 32'd4);
    check("tick_gate_y", 32'(y), 32'h2);

    // Independent bits: a[3] at cycle 0, a[0] at cycle 2.
    r3 = 0; r0 = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, (k >= 3) ? 4'hB : 4'hA);
      if (rise[3]) r3 = k;
      if (rise[0]) r0 = k;
    end
    check("indep_rise3", 32'(r3), 32'd6);
    check("indep_rise0", 32'(r0), 32'd8);

    // Settle low, then async reset two qualifying edges into a count on a[2].
    for (int k = 0; k < 10; k++) step(1'b1, 4'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'h4);
    reset = 1'b1;
    #1;
    check("async_y", 32'(y), 32'h0);
    check("async_rise", 32'(rise), 32'h0);
    check("async_fall", 32'(fall), 32'h0);
    model_reset();
    #2 reset = 1'b0;
    #1;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 4'h4);
      if (rise[2]) begin edges = k; break; end
    end
    check("async_recount", 32'(edges), 32'd6);

    // Random inputs and tick, checked cycle by cycle against the model.
    av = 4'h4;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) av[$urandom_range(0, SIZE - 1)] ^= 1'b1;
      step(1'($urandom_range(0, 3) != 0), av);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
